// File: rtl/reg_scoreboard_ctl.sv
// Issue/stall controller between decode and AG: tracks in-flight GPR writes per register,
// holds decode on RAW hazards or counter saturation, and handles flush and a stall watchdog.
module reg_scoreboard_ctl #(
    parameter int NREGS         = 8,
    parameter int CNT_W         = 3,
    parameter int STALL_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             de_v,
    input  logic [7:0]       de_modrm,
    input  logic             de_ro_needed,
    input  logic             de_rm_needed,
    input  logic             de_we,
    input  logic             de_rmsel,
    input  logic             ag_ready,
    input  logic             wb_v,
    input  logic [2:0]       wb_reg,
    input  logic             flush,
    output logic             de_issue,
    output logic             de_stall,
    output logic [NREGS-1:0] busy,
    output logic             err
);

    localparam int              SC_W    = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STALL_TIMEOUT);
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE_ST  = 2'd0,
        RUN_ST   = 2'd1,
        STALL_ST = 2'd2,
        FLUSH_ST = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r [NREGS];
    logic [CNT_W-1:0] cnt_s [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_s;
    logic [NREGS-1:0] inc_vec_s;
    logic [NREGS-1:0] dec_vec_s;
    logic [SC_W-1:0]  stall_cnt_r;
    logic [SC_W-1:0]  stall_cnt_s;
    logic             err_r;
    logic             err_s;

    logic [1:0] mod_s;
    logic [2:0] ro_s;
    logic [2:0] rm_s;
    logic [2:0] dest_s;
    logic       dest_valid_s;
    logic       hazard_s;
    logic       sat_s;
    logic       blocked_s;
    logic       run_ok_s;
    logic       issue_s;
    logic       underflow_s;
    logic       timeout_s;

    // Operand decode and the issue decision; hazards look only at registered counters.
    always_comb begin
        mod_s        = de_modrm[7:6];
        ro_s         = de_modrm[5:3];
        rm_s         = de_modrm[2:0];
        dest_valid_s = de_we & (~de_rmsel | (mod_s == 2'b11));
        if (de_rmsel) begin
            dest_s = rm_s;
        end else begin
            dest_s = ro_s;
        end
        hazard_s  = (de_ro_needed & busy_r[ro_s]) |
                    (de_rm_needed & (mod_s == 2'b11) & busy_r[rm_s]);
        sat_s     = dest_valid_s & (cnt_r[dest_s] == CNT_MAX);
        blocked_s = hazard_s | sat_s;
        run_ok_s  = (state_r == RUN_ST) | (state_r == STALL_ST);
        issue_s   = de_v & ag_ready & ~blocked_s & ~flush & run_ok_s;
    end

    assign de_issue = issue_s;
    assign de_stall = de_v & ~issue_s;
    assign busy     = busy_r;
    assign err      = err_r;

    // Next-state logic; flush wins over every other transition.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = FLUSH_ST;
        end else begin
            case (state_r)
                IDLE_ST:  state_s = RUN_ST;
                RUN_ST:   state_s = (de_v & blocked_s) ? STALL_ST : RUN_ST;
                STALL_ST: state_s = (~blocked_s | ~de_v) ? RUN_ST : STALL_ST;
                FLUSH_ST: state_s = RUN_ST;
                default:  state_s = IDLE_ST;
            endcase
        end
    end

    // Per-register increment/decrement requests for this cycle.
    always_comb begin
        inc_vec_s = {NREGS{1'b0}};
        dec_vec_s = {NREGS{1'b0}};
        for (int r = 0; r < NREGS; r++) begin
            inc_vec_s[r] = issue_s & dest_valid_s & (dest_s == 3'(r));
            dec_vec_s[r] = wb_v & (wb_reg == 3'(r));
        end
    end

    // Counter update; a writeback against an empty counter leaves it at zero.
    always_comb begin
        busy_s = {NREGS{1'b0}};
        for (int r = 0; r < NREGS; r++) begin
            if (flush) begin
                cnt_s[r] = {CNT_W{1'b0}};
            end else if (inc_vec_s[r] & ~dec_vec_s[r]) begin
                cnt_s[r] = cnt_r[r] + CNT_W'(1);
            end else if (dec_vec_s[r] & ~inc_vec_s[r] & (cnt_r[r] != {CNT_W{1'b0}})) begin
                cnt_s[r] = cnt_r[r] - CNT_W'(1);
            end else begin
                cnt_s[r] = cnt_r[r];
            end
            busy_s[r] = (cnt_s[r] != {CNT_W{1'b0}});
        end
    end

    // Watchdog counts cycles spent in STALL; err is sticky until rst_n.
    always_comb begin
        stall_cnt_s = {SC_W{1'b0}};
        timeout_s   = 1'b0;
        underflow_s = wb_v & ~flush & (cnt_r[wb_reg] == {CNT_W{1'b0}});
        if (flush) begin
            stall_cnt_s = {SC_W{1'b0}};
        end else if (state_r == STALL_ST) begin
            if (stall_cnt_r != SC_MAX) begin
                stall_cnt_s = stall_cnt_r + SC_W'(1);
            end else begin
                stall_cnt_s = SC_MAX;
            end
            timeout_s = (stall_cnt_r == SC_LAST);
        end else begin
            stall_cnt_s = {SC_W{1'b0}};
        end
        err_s = err_r | underflow_s | timeout_s;
    end

    // State, counters, watchdog and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE_ST;
            busy_r      <= {NREGS{1'b0}};
            stall_cnt_r <= {SC_W{1'b0}};
            err_r       <= 1'b0;
            for (int r = 0; r < NREGS; r++) begin
                cnt_r[r] <= {CNT_W{1'b0}};
            end
        end else begin
            state_r     <= state_s;
            busy_r      <= busy_s;
            stall_cnt_r <= stall_cnt_s;
            err_r       <= err_s;
            for (int r = 0; r < NREGS; r++) begin
                cnt_r[r] <= cnt_s[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard_ctl.sv
// Directed and randomized bench for reg_scoreboard_ctl against a counting reference model.
module tb_reg_scoreboard_ctl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       de_v;
    logic [7:0] de_modrm;
    logic       de_ro_needed;
    logic       de_rm_needed;
    logic       de_we;
    logic       de_rmsel;
    logic       ag_ready;
    logic       wb_v;
    logic [2:0] wb_reg;
    logic       flush;
    logic       de_issue;
    logic       de_stall;
    logic [7:0] busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model: in-flight counts, sticky error, stall-run length.
    int m_cnt [8];
    bit m_err;
    bit m_quiet;
    bit m_in_stall;
    int m_stall_len;

    reg_scoreboard_ctl dut (
        .clk(clk), .rst_n(rst_n), .de_v(de_v), .de_modrm(de_modrm),
        .de_ro_needed(de_ro_needed), .de_rm_needed(de_rm_needed), .de_we(de_we),
        .de_rmsel(de_rmsel), .ag_ready(ag_ready), .wb_v(wb_v), .wb_reg(wb_reg),
        .flush(flush), .de_issue(de_issue), .de_stall(de_stall), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] modrm, input bit ron, input bit rmn,
                         input bit we, input bit rmsel, input bit rdy, input bit wbv,
                         input logic [2:0] wbr, input bit fl);
        de_v = v; de_modrm = modrm; de_ro_needed = ron; de_rm_needed = rmn;
        de_we = we; de_rmsel = rmsel; ag_ready = rdy; wb_v = wbv; wb_reg = wbr; flush = fl;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) m_cnt[r] = 0;
        m_err = 0; m_quiet = 1; m_in_stall = 0; m_stall_len = 0;
    endtask

    // One clock: compare outputs against the model, then advance the model over the edge.
    task automatic step();
        int md, ro, rm, dst;
        bit dv, hz, sat, blk, iss, uf;
        logic [7:0] eb;
        #1;
        md  = int'(de_modrm[7:6]);
        ro  = int'(de_modrm[5:3]);
        rm  = int'(de_modrm[2:0]);
        dv  = de_we && (!de_rmsel || md == 3);
        dst = de_rmsel ? rm : ro;
        hz  = (de_ro_needed && m_cnt[ro] > 0) || (de_rm_needed && md == 3 && m_cnt[rm] > 0);
        sat = dv && (m_cnt[dst] == 7);
        blk = hz || sat;
        iss = de_v && ag_ready && !blk && !flush && !m_quiet;
        for (int r = 0; r < 8; r++) eb[r] = (m_cnt[r] > 0);
        check("de_issue", 32'(de_issue), 32'(iss));
        check("de_stall", 32'(de_stall), 32'(de_v && !iss));
        check("busy", 32'(busy), 32'(eb));
        check("err", 32'(err), 32'(m_err));
        @(posedge clk);
        if (flush) begin
            for (int r = 0; r < 8; r++) m_cnt[r] = 0;
            m_stall_len = 0; m_in_stall = 0; m_quiet = 1;
        end else begin
            if (m_in_stall) begin
                m_stall_len++;
                if (m_stall_len == 15) m_err = 1;
            end else begin
                m_stall_len = 0;
            end
            uf = wb_v && (m_cnt[wb_reg] == 0);
            if (uf) m_err = 1;
            if (iss && dv && !(uf && int'(wb_reg) == dst)) m_cnt[dst]++;
            if (wb_v && !uf) m_cnt[wb_reg]--;
            m_in_stall = !m_quiet && de_v && blk;
            m_quiet = 0;
        end
        #1;
    endtask

    // Asynchronous reset mid-cycle, with decode and writeback active while held.
    task automatic do_reset();
        drive(1, 8'hC8, 1, 1, 1, 0, 1, 1, 3'd3, 0);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_issue", 32'(de_issue), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        drive(1, 8'hC8, 0, 0, 0, 0, 1, 0, 3'd0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 8'h00, 0, 0, 0, 0, 0, 0, 3'd0, 0);
        model_reset();
        #2;
        do_reset();

        // IDLE cycle suppresses issue, RUN allows it
        step();
        step();
        check("t1_run_issue", 32'(de_issue), 32'h1);

        // RAW on ro=1 held until writeback, issue one cycle after
        drive(1, 8'hC8, 0, 0, 1, 0, 1, 0, 3'd0, 0);
        step();
        check("t2_busy", 32'(busy), 32'h02);
        drive(1, 8'hC8, 1, 0, 0, 0, 1, 0, 3'd0, 0);
        step();
        step();
        check("t2_stall", 32'(de_stall), 32'h1);
        drive(1, 8'hC8, 1, 0, 0, 0, 1, 1, 3'd1, 0);
        step();
        check("t2_issue", 32'(de_issue), 32'h1);
        drive(1, 8'hC8, 1, 0, 0, 0, 1, 0, 3'd0, 0);
        step();

        // Issue and writeback to reg 2 in the same cycle
        drive(1, 8'hD0, 0, 0, 1, 0, 1, 0, 3'd0, 0);
        step();
        drive(1, 8'hD0, 0, 0, 1, 0, 1, 1, 3'd2, 0);
        step();
        check("t3_busy2", 32'(busy[2]), 32'h1);
        drive(0, 8'h00, 0, 0, 0, 0, 1, 1, 3'd2, 0);
        step();
        check("t3_busy2_clr", 32'(busy[2]), 32'h0);

        // Saturation on reg 3
        drive(1, 8'hD8, 0, 0, 1, 0, 1, 0, 3'd0, 0);
        repeat (7) step();
        check("t4_sat_stall", 32'(de_stall), 32'h1);
        step();
        drive(1, 8'hD8, 0, 0, 1, 0, 1, 1, 3'd3, 0);
        step();
        check("t4_issue", 32'(de_issue), 32'h1);
        drive(1, 8'hD8, 0, 0, 1, 0, 1, 0, 3'd0, 0);
        step();

        // Fill every register, then flush with a writeback
        for (int r = 0; r < 8; r++) begin
            if (r != 3) begin
                drive(1, {2'b11, 3'(r), 3'b000}, 0, 0, 1, 0, 1, 0, 3'd0, 0);
                step();
            end
        end
        check("t5_busy_ff", 32'(busy), 32'hFF);
        drive(1, 8'hC0, 0, 0, 0, 0, 1, 1, 3'd0, 1);
        step();
        check("t5_busy0", 32'(busy), 32'h0);
        check("t5_err0", 32'(err), 32'h0);
        drive(1, 8'hC0, 0, 0, 0, 0, 1, 0, 3'd0, 0);
        step();
        step();
        drive(0, 8'h00, 0, 0, 0, 0, 1, 1, 3'd6, 1);
        step();
        check("t5_flush_uf", 32'(err), 32'h0);
        drive(0, 8'h00, 0, 0, 0, 0, 1, 0, 3'd0, 0);
        step();
        drive(1, 8'h05, 0, 0, 1, 1, 1, 0, 3'd0, 0);
        step();
        check("t5_memdest", 32'(busy), 32'h0);

        // Underflow is sticky
        drive(0, 8'h00, 0, 0, 0, 0, 1, 1, 3'd5, 0);
        step();
        check("t6_uf", 32'(err), 32'h1);
        drive(0, 8'h00, 0, 0, 0, 0, 1, 0, 3'd0, 0);
        repeat (3) step();
        check("t6_sticky", 32'(err), 32'h1);

        // Mid-operation reset, then watchdog on a held hazard
        drive(1, 8'hE0, 0, 0, 1, 0, 1, 0, 3'd0, 0);
        step();
        do_reset();
        drive(1, 8'hE0, 0, 0, 1, 0, 1, 0, 3'd0, 0);
        step();
        step();
        drive(1, 8'hE0, 1, 0, 0, 0, 1, 0, 3'd0, 0);
        step();
        repeat (14) step();
        check("t6_wd_pre", 32'(err), 32'h0);
        step();
        check("t6_wd", 32'(err), 32'h1);
        step();

        // Randomized traffic after a fresh reset
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            de_v         = ($urandom_range(0, 3) != 0);
            de_modrm     = 8'($urandom);
            de_ro_needed = 1'($urandom);
            de_rm_needed = 1'($urandom);
            de_we        = 1'($urandom);
            de_rmsel     = 1'($urandom);
            ag_ready     = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 39) == 0);
            wb_reg       = 3'(r);
            wb_v         = (m_cnt[r] > 0) && ($urandom_range(0, 1) == 1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
